pe_mac_accum: RTL and testbench
===============================

Name: pe_mac_accum

Overview:
Clocked multiply-accumulate stage inside the PE, directly downstream of the operand copy/fork stage. It joins one ifmap operand stream and one filter operand stream pairwise and multiplies each pair. It accumulates KSIZE products, optionally adds an incoming partial sum, and emits one partial sum per window. It is the consumer of the duplicated operand packets and produces the PE's psum output.

Parameters:
DWIDTH, 8, width of ifmap and filter operands (signed two's complement)
PWIDTH, 16, width of accumulator, psum in and psum out (signed)
KSIZE, 3, operand pairs accumulated per output psum (>=1)
USE_PSIN, 1, 1 = add psin_data before output; 0 = skip psum input, psin_ready tied 0

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
ifm_valid  input  1  ifmap operand valid
ifm_ready  output  1  ifmap operand accepted
ifm_data  input  DWIDTH  ifmap operand
flt_valid  input  1  filter operand valid
flt_ready  output  1  filter operand accepted
flt_data  input  DWIDTH  filter operand
psin_valid  input  1  incoming partial sum valid
psin_ready  output  1  incoming partial sum accepted
psin_data  input  PWIDTH  incoming partial sum
out_valid  output  1  output psum valid
out_ready  input  1  downstream accepts psum
out_data  output  PWIDTH  output psum

Behaviour:
- Interfaces are valid/ready; a transfer occurs on a rising edge with valid&ready high. Once asserted, valid and data stay stable until the transfer.
- Reset (rst_n low, async): state=ACC, acc=0, cnt=0, out_valid=0, out_data=0, all ready outputs low while in reset.
- FSM states: ACC, ADD, OUT.
- ACC:
  - ifm_ready = flt_valid.
  - flt_ready = ifm_valid.
  - The pair fires only when both valids are high, in the same cycle. A lone operand is never consumed.
  - On fire: acc <= acc + sext(ifm_data*flt_data), full signed 2*DWIDTH product, sign-extended or truncated to PWIDTH; cnt <= cnt+1.
  - On the fire with cnt==KSIZE-1: cnt<=0 and go to ADD (USE_PSIN=1), or load out_data <= acc+product, set out_valid=1, and go to OUT (USE_PSIN=0).
- ADD:
  - psin_ready=1, operand readies are 0.
  - On psin fire: out_data <= acc + psin_data, out_valid <= 1, go to OUT.
- OUT:
  - out_valid=1; all input readies are 0.
  - On out_ready: out_valid <= 0, acc <= 0, return to ACC.
  - The next window begins the cycle after the handshake; there is no same-cycle overlap.
- Arithmetic: all sums wrap modulo 2^PWIDTH, with no saturation and no overflow flag.
- Latency:
  - USE_PSIN=0: out_valid rises the cycle after the KSIZE-th pair fires.
  - USE_PSIN=1: out_valid rises the cycle after psin fires.
- psin_valid asserted early (during ACC) is ignored until ADD; it must be held by the producer.
- Backpressure: out_ready low holds out_data and out_valid indefinitely; the inputs stall.
- KSIZE=1: every pair fire leaves ACC immediately.
- Reset asserted mid-window or in OUT: partial acc, cnt, and pending output are discarded; the state returns to ACC with zeroed registers.

Test Plan:
- KSIZE=3, USE_PSIN=1: pairs (1,2),(3,4),(5,6), psin=10, out_ready=1 -> out_data=54, out_valid one cycle after psin fire.
- Signed: pairs (-2,3),(4,-5),(-1,-1), psin=0 -> out_data=-25 (16'hFFE7).
- Join skew: ifm_valid high 4 cycles before flt_valid -> no fire and ifm_ready low until flt_valid; acc unchanged; result matches the aligned case.
- Backpressure: out_ready low 5 cycles -> out_data stable, ifm_ready/flt_ready/psin_ready all 0; the new window starts after the handshake.
- Wrap: PWIDTH=16, pairs (127,127)x3, psin=16'h7FFF -> out_data = (48387+32767) mod 65536 = 15618.
- Reset mid-window after 2 pairs, then pairs (1,1)x3, psin=0 -> out_data=3, with no residue from before reset.

Source files
------------

// File: rtl/pe_mac_accum.sv
// Multiply-accumulate stage of the PE: joins ifmap/filter operand pairs, sums KSIZE
// products, optionally adds an incoming partial sum, and holds the result until taken.
module pe_mac_accum #(
    parameter int DWIDTH   = 8,
    parameter int PWIDTH   = 16,
    parameter int KSIZE    = 3,
    parameter int USE_PSIN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifm_valid,
    output logic              ifm_ready,
    input  logic [DWIDTH-1:0] ifm_data,
    input  logic              flt_valid,
    output logic              flt_ready,
    input  logic [DWIDTH-1:0] flt_data,
    input  logic              psin_valid,
    output logic              psin_ready,
    input  logic [PWIDTH-1:0] psin_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PWIDTH-1:0] out_data,
    output logic [1:0]        state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the producer
    // keeps valid and data stable until then, and ready never waits on the transfer itself.

    localparam int CW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(KSIZE - 1);

    typedef enum logic [1:0] {
        ACC = 2'd0,
        ADD = 2'd1,
        OUT = 2'd2
    } state_t;

    state_t                   state;
    logic signed [PWIDTH-1:0] acc;
    logic [CW-1:0]            cnt;
    logic signed [2*DWIDTH-1:0] prod;
    logic signed [PWIDTH-1:0] prod_ext;
    logic signed [PWIDTH-1:0] acc_sum;
    logic                     pair_fire;
    logic                     psin_fire;

    assign prod = $signed(ifm_data) * $signed(flt_data);

    // Fit the full-width product to the accumulator: sign-extend or truncate.
    generate
        if (PWIDTH > 2*DWIDTH) begin : g_ext
            assign prod_ext = {{(PWIDTH-2*DWIDTH){prod[2*DWIDTH-1]}}, prod};
        end else if (PWIDTH == 2*DWIDTH) begin : g_same
            assign prod_ext = prod;
        end else begin : g_trunc
            assign prod_ext = prod[PWIDTH-1:0];
        end
    endgenerate

    assign acc_sum = acc + prod_ext;

    // Each operand side is ready only when its partner is valid, so a lone operand is never taken.
    assign ifm_ready = rst_n && (state == ACC) && flt_valid;
    assign flt_ready = rst_n && (state == ACC) && ifm_valid;

    generate
        if (USE_PSIN != 0) begin : g_psin
            assign psin_ready = rst_n && (state == ADD);
        end else begin : g_nopsin
            assign psin_ready = 1'b0;
        end
    endgenerate

    assign pair_fire = (state == ACC) && ifm_valid && flt_valid;
    assign psin_fire = psin_ready && psin_valid;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (pair_fire) begin
                        acc <= acc_sum;
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (USE_PSIN != 0) begin
                                state <= ADD;
                            end else begin
                                out_data  <= acc_sum;
                                out_valid <= 1'b1;
                                state     <= OUT;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ADD: begin
                    if (psin_fire) begin
                        out_data  <= acc + $signed(psin_data);
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        state     <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_mac_accum.sv
// Directed bench for pe_mac_accum (DWIDTH=8, PWIDTH=16, KSIZE=3, USE_PSIN=1) with
// hand-computed window results and immediate assertions at every check point.
module tb_pe_mac_accum;

    localparam logic [1:0] S_ACC = 2'd0;
    localparam logic [1:0] S_ADD = 2'd1;
    localparam logic [1:0] S_OUT = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        ifm_valid;
    logic        ifm_ready;
    logic [7:0]  ifm_data;
    logic        flt_valid;
    logic        flt_ready;
    logic [7:0]  flt_data;
    logic        psin_valid;
    logic        psin_ready;
    logic [15:0] psin_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    pe_mac_accum #(
        .DWIDTH(8), .PWIDTH(16), .KSIZE(3), .USE_PSIN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_data(ifm_data),
        .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_data(flt_data),
        .psin_valid(psin_valid), .psin_ready(psin_ready), .psin_data(psin_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one operand pair and wait (bounded) for the edge on which it fires.
    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        logic fired;
        fired = 1'b0;
        @(negedge clk);
        ifm_valid = 1'b1; flt_valid = 1'b1; ifm_data = a; flt_data = b;
        for (int i = 0; i < 20 && !fired; i++) begin
            #1 fired = ifm_ready && flt_ready;
            @(posedge clk);
        end
        #1 ifm_valid = 1'b0; flt_valid = 1'b0;
        check("pair_fire", {15'd0, fired}, 16'd1);
    endtask

    // Offer a partial sum; out_valid must be low on the fire edge and high right after it.
    task automatic send_psin(input logic [15:0] p, input logic [15:0] exp_out);
        logic fired;
        logic ov_before;
        fired = 1'b0;
        ov_before = 1'b1;
        @(negedge clk);
        psin_valid = 1'b1; psin_data = p;
        for (int i = 0; i < 20 && !fired; i++) begin
            #1 fired = psin_ready;
            ov_before = out_valid;
            @(posedge clk);
        end
        #1 psin_valid = 1'b0;
        check("psin_fire", {15'd0, fired}, 16'd1);
        check("out_valid_before", {15'd0, ov_before}, 16'd0);
        check("out_valid_after", {15'd0, out_valid}, 16'd1);
        check("out_data", out_data, exp_out);
    endtask

    // Accept the held psum and confirm the block returns to ACC.
    task automatic take_out();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        ifm_valid = 1'b0; flt_valid = 1'b0; psin_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1 seen = out_valid;
            @(posedge clk);
        end
        #1 out_ready = 1'b0;
        check("out_seen", {15'd0, seen}, 16'd1);
        check("out_cleared", {15'd0, out_valid}, 16'd0);
        check("state_acc", {14'd0, state_dbg}, {14'd0, S_ACC});
    endtask

    initial begin
        rst_n = 1'b0;
        ifm_valid = 1'b1; flt_valid = 1'b1; psin_valid = 1'b1; out_ready = 1'b0;
        ifm_data = 8'd0; flt_data = 8'd0; psin_data = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_data", out_data, 16'd0);
        check("rst_ifm_ready", {15'd0, ifm_ready}, 16'd0);
        check("rst_flt_ready", {15'd0, flt_ready}, 16'd0);
        check("rst_psin_ready", {15'd0, psin_ready}, 16'd0);
        check("rst_state", {14'd0, state_dbg}, {14'd0, S_ACC});
        ifm_valid = 1'b0; flt_valid = 1'b0; psin_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Basic window: 2+12+30+10 = 54
        send_pair(8'd1, 8'd2);
        send_pair(8'd3, 8'd4);
        send_pair(8'd5, 8'd6);
        check("add_state", {14'd0, state_dbg}, {14'd0, S_ADD});
        check("add_psin_ready", {15'd0, psin_ready}, 16'd1);
        check("add_ifm_ready", {15'd0, ifm_ready}, 16'd0);
        send_psin(16'd10, 16'd54);
        take_out();

        // Signed window with psin raised early: -6-20+1 = -25
        @(negedge clk);
        psin_valid = 1'b1; psin_data = 16'd0;
        #1 check("early_psin_ready", {15'd0, psin_ready}, 16'd0);
        send_pair(8'hFE, 8'd3);
        send_pair(8'd4, 8'hFB);
        send_pair(8'hFF, 8'hFF);
        send_psin(16'd0, 16'hFFE7);
        take_out();

        // Join skew: ifmap waits 4 cycles alone
        @(negedge clk);
        ifm_valid = 1'b1; ifm_data = 8'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("skew_ifm_ready", {15'd0, ifm_ready}, 16'd0);
            check("skew_flt_ready", {15'd0, flt_ready}, 16'd1);
            @(negedge clk);
        end
        check("skew_state", {14'd0, state_dbg}, {14'd0, S_ACC});
        send_pair(8'd1, 8'd2);
        send_pair(8'd3, 8'd4);
        check("skew_mid_state", {14'd0, state_dbg}, {14'd0, S_ACC});
        send_pair(8'd5, 8'd6);
        send_psin(16'd10, 16'd54);
        take_out();

        // Backpressure: 4+4+4+0 = 12 held for 5 cycles with all inputs pushing
        send_pair(8'd2, 8'd2);
        send_pair(8'd2, 8'd2);
        send_pair(8'd2, 8'd2);
        send_psin(16'd0, 16'd12);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ifm_valid = 1'b1; flt_valid = 1'b1; psin_valid = 1'b1;
            ifm_data = 8'd9; flt_data = 8'd9; psin_data = 16'd7;
            #1;
            check("bp_out_valid", {15'd0, out_valid}, 16'd1);
            check("bp_out_data", out_data, 16'd12);
            check("bp_readies", {13'd0, ifm_ready, flt_ready, psin_ready}, 16'd0);
        end
        take_out();
        // New window right after the handshake: 3*3+1*1+0 = 10
        send_pair(8'd3, 8'd3);
        send_pair(8'd1, 8'd1);
        send_pair(8'd0, 8'd5);
        send_psin(16'd0, 16'd10);
        take_out();

        // Wrap: 3*16129 + 32767 = 81154 -> 15618
        send_pair(8'd127, 8'd127);
        send_pair(8'd127, 8'd127);
        send_pair(8'd127, 8'd127);
        send_psin(16'h7FFF, 16'd15618);
        take_out();

        // Reset after two pairs discards the partial window
        send_pair(8'd5, 8'd5);
        send_pair(8'd7, 8'd7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_state", {14'd0, state_dbg}, {14'd0, S_ACC});
        check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_pair(8'd1, 8'd1);
        send_pair(8'd1, 8'd1);
        send_pair(8'd1, 8'd1);
        send_psin(16'd0, 16'd3);
        take_out();

        // Reset while an output is pending drops it
        send_pair(8'd2, 8'd3);
        send_pair(8'd2, 8'd3);
        send_pair(8'd2, 8'd3);
        send_psin(16'd1, 16'd19);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("outrst_out_valid", {15'd0, out_valid}, 16'd0);
        check("outrst_out_data", out_data, 16'd0);
        check("outrst_state", {14'd0, state_dbg}, {14'd0, S_ACC});
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
